if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter ADDR_W, default 32, giving the PC width.
REQ-003 The module SHALL have parameter INST_W, default 32, giving the instruction width.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-006 rdy  input  1  global enable; when 0, all state SHALL hold.
REQ-007 in_valid  input  1  fetch offers an entry.
REQ-008 in_ready  output  1  queue accepts an entry; equals (count != DEPTH).
REQ-009 in_pc  input  ADDR_W  PC of the offered instruction.
REQ-010 in_inst  input  INST_W  offered instruction word.
REQ-011 flush  input  1  branch/jump redirect; discards all entries.
REQ-012 out_valid  output  1  head entry present; equals (count != 0).
REQ-013 out_ready  input  1  decode consumes the head (deasserted on a decode stall).
REQ-014 out_pc  output  ADDR_W  head PC; zero when empty.
REQ-015 out_inst  output  INST_W  head instruction; zero (bubble) when empty.
REQ-016 out_rs1, out_rs2, out_rd  output  5 each  head inst[19:15], inst[24:20], inst[11:7]; zero when empty.
REQ-017 out_opcode  output  7  head inst[6:0]; zero when empty.
REQ-018 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-019 Push: SHALL occur on a rising edge with rst=1, rdy=1, flush=0, in_valid=1 and in_ready=1; the entry SHALL be written at the write pointer and the write pointer SHALL advance by 1 modulo DEPTH.
REQ-020 Pop: SHALL occur on a rising edge with rst=1, rdy=1, flush=0, out_valid=1 and out_ready=1; the read pointer SHALL advance by 1 modulo DEPTH.
REQ-021 Latency: an entry pushed at edge N SHALL appear on out_* after edge N when the queue was empty (one cycle in, combinational read of head).
REQ-022 Simultaneous push and pop SHALL leave count unchanged; when count=DEPTH, in_ready=0 regardless of out_ready (no combinational in_ready/out_ready path).
REQ-023 A push with in_ready=0 SHALL be ignored; a pop with out_valid=0 SHALL be ignored; count SHALL never exceed DEPTH or go below 0.
REQ-024 Order SHALL be strict FIFO across pointer wrap-around.
REQ-025 Flush SHALL take priority over push and pop: on an edge with flush=1 and rdy=1, both pointers and count SHALL become 0 and the input entry SHALL be dropped.
REQ-026 rdy=0 SHALL block push, pop and flush on that edge; outputs SHALL remain driven from held state.
REQ-027 Pre-decode fields SHALL be pure slices of the head entry, with no added latency.
REQ-028 Storage contents beyond count SHALL NOT be observable on any output.

Reset
REQ-029 While rst=0, pointers and count SHALL be 0 immediately (asynchronously), giving out_valid=0, in_ready=1, and all out_* zero.
REQ-030 Storage array contents SHALL need no reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL be the first popped.

Verification
REQ-032 After reset, push pc=0x0,0x4,0x8 with inst=0x00500093,0x00100113,0x002081B3 and out_ready=0 -> count=3; then pop -> out_pc=0x0, out_rd=1, out_rs1=0, out_opcode=0x13, in that order.
REQ-033 Fill DEPTH=4 with out_ready=0 -> in_ready=0 at count=4; a fifth push (pc=0x10) is dropped; draining yields 0x0,0x4,0x8,0xC.
REQ-034 Hold count=2 with continuous simultaneous push/pop for 10 cycles -> count stays 2, pops are in PC order, and pointer wrap is correct.
REQ-035 At count=3, assert flush together with in_valid=1 (pc=0x40) -> next cycle count=0, out_valid=0, out_inst=0; pc 0x40 never appears.
REQ-036 At count=2, hold rdy=0 for 3 cycles with push and pop requests -> count=2 and out_pc unchanged; then drive rst=0 between clock edges -> out_valid=0 immediately.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO of {pc, inst} with pre-decoded head fields.
// One cycle in (write at edge), combinational head read; in_ready drops at full, rdy=0 freezes all state.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [6:0]                 out_opcode,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  // Flush and rdy gate both sides so a redirect never lets an entry slip through.
  assign push = rdy && !flush && in_valid && in_ready;
  assign pop  = rdy && !flush && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Payload storage carries no reset; stale slots are masked by out_valid below.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_comb begin
    head_pc   = '0;
    head_inst = '0;
    if (out_valid) begin
      head_pc   = pc_mem[rd_ptr];
      head_inst = inst_mem[rd_ptr];
    end
  end

  assign out_pc     = head_pc;
  assign out_inst   = head_inst;
  assign out_rs1    = head_inst[19:15];
  assign out_rs2    = head_inst[24:20];
  assign out_rd     = head_inst[11:7];
  assign out_opcode = head_inst[6:0];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed scenarios plus randomized traffic against a queue-based reference model of the IF/ID queue.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  count;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [63:0] model_q [$];  // {pc, inst}, head at index 0
  logic [31:0] next_pc;

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_opcode(out_opcode),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] hpc, hinst;
    hpc   = 32'h0;
    hinst = 32'h0;
    if (model_q.size() != 0) begin
      hpc   = model_q[0][63:32];
      hinst = model_q[0][31:0];
    end
    check("count",     64'(count),     64'(model_q.size()));
    check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    check("in_ready",  64'(in_ready),  64'(model_q.size() != DEPTH));
    check("out_pc",    64'(out_pc),    64'(hpc));
    check("out_inst",  64'(out_inst),  64'(hinst));
    check("out_rs1",   64'(out_rs1),   64'((hinst >> 15) & 32'h1f));
    check("out_rs2",   64'(out_rs2),   64'((hinst >> 20) & 32'h1f));
    check("out_rd",    64'(out_rd),    64'((hinst >> 7) & 32'h1f));
    check("out_opcode",64'(out_opcode),64'(hinst & 32'h7f));
  endtask

  // Called at a falling edge; drives one cycle of stimulus and advances the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic r);
    bit do_pop, do_push;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    rdy       = r;
    #1 check_outputs();
    @(posedge clk);
    if (r) begin
      if (fl) begin
        model_q.delete();
      end else begin
        do_pop  = ordy && (model_q.size() != 0);
        do_push = v && (model_q.size() != DEPTH);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back({pc, inst});
      end
    end
    @(negedge clk);
  endtask

  task automatic push_pc(input logic [31:0] pc, input logic [31:0] inst);
    step(1'b1, pc, inst, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases on the next falling edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"}, 64'(in_ready),  64'd1);
    check({tag, "_count"}, 64'(count),     64'd0);
    check({tag, "_inst"},  64'(out_inst),  64'd0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready),  64'd1);
    check("rst_count", 64'(count),     64'd0);
    check("rst_pc",    64'(out_pc),    64'd0);
    rst = 1'b1;

    // Three pushes, then inspect and pop the head.
    push_pc(32'h0, 32'h00500093);
    push_pc(32'h4, 32'h00100113);
    push_pc(32'h8, 32'h002081B3);
    check("d1_count",  64'(count),      64'd3);
    check("d1_pc",     64'(out_pc),     64'h0);
    check("d1_rd",     64'(out_rd),     64'd1);
    check("d1_rs1",    64'(out_rs1),    64'd0);
    check("d1_opcode", 64'(out_opcode), 64'h13);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("d1_pop_pc", 64'(out_pc), 64'h4);
    async_reset("d1_rst");

    // Fill to full, attempt an overflow push, drain in order.
    for (int i = 0; i < 4; i++) push_pc(32'(i * 4), 32'h00000013 | 32'(i << 7));
    check("d2_full_ready", 64'(in_ready), 64'd0);
    check("d2_full_count", 64'(count),    64'd4);
    push_pc(32'h10, 32'h00000013);
    for (int i = 0; i < 4; i++) begin
      check("d2_drain_pc", 64'(out_pc), 64'(i * 4));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    end
    check("d2_empty", 64'(out_valid), 64'd0);

    // Steady state at count=2 with simultaneous push/pop across pointer wrap.
    push_pc(32'h0, 32'h00000093);
    push_pc(32'h4, 32'h00000113);
    for (int k = 0; k < 10; k++) begin
      check("d3_count", 64'(count),  64'd2);
      check("d3_pc",    64'(out_pc), 64'(k * 4));
      step(1'b1, 32'((k + 2) * 4), $urandom, 1'b1, 1'b0, 1'b1);
    end
    check("d3_count_end", 64'(count), 64'd2);
    async_reset("d3_rst");

    // Flush wins over a simultaneous push.
    push_pc(32'h0, 32'h00000093);
    push_pc(32'h4, 32'h00000113);
    push_pc(32'h8, 32'h00000193);
    step(1'b1, 32'h40, 32'hdeadbeef, 1'b1, 1'b1, 1'b1);
    check("d4_count", 64'(count),     64'd0);
    check("d4_valid", 64'(out_valid), 64'd0);
    check("d4_inst",  64'(out_inst),  64'd0);
    push_pc(32'h80, 32'h00000213);
    check("d4_after_pc", 64'(out_pc), 64'h80);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // rdy=0 freezes everything; then reset mid-operation.
    push_pc(32'h100, 32'h00000093);
    push_pc(32'h104, 32'h00000113);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h200, 32'h0, 1'b1, 1'b1, 1'b0);
    check("d5_count", 64'(count),  64'd2);
    check("d5_pc",    64'(out_pc), 64'h100);
    async_reset("d5_rst");
    push_pc(32'h300, 32'h00000313);
    check("d5_first_pc", 64'(out_pc), 64'h300);

    // Randomized traffic.
    next_pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 3) != 0, next_pc, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 9) != 0);
        next_pc = next_pc + 32'd4;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
